// File: rtl/branch_pkg.sv
// Shared types and constants for the local branch predictor.
package branch_pkg;

    localparam int BP_ENTRIES = 128;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);

    // 2-bit saturating direction counter; the MSB is the taken/not-taken decision.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_INIT = WNT;

endpackage

// File: rtl/branch_local_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating counter: taken moves toward ST,
// not-taken toward SNT, both ends hold.
module sat_counter2
    import branch_pkg::*;
(
    input  bp_ctr_t i_ctr,
    input  logic    i_taken,
    output bp_ctr_t o_ctr
);

    // Saturating step in the resolved direction.
    always_comb begin
        o_ctr = i_ctr;
        unique case (i_ctr)
            SNT: o_ctr = i_taken ? WNT : SNT;
            WNT: o_ctr = i_taken ? WT  : SNT;
            WT:  o_ctr = i_taken ? ST  : WNT;
            ST:  o_ctr = i_taken ? ST  : WT;
            default: o_ctr = i_ctr;
        endcase
    end

endmodule

// File: rtl/branch_local_predictor.sv
// Local (per-PC) branch direction predictor: a table of 2-bit counters with
// full-PC tags. IF reads combinationally, EX writes the resolved outcome.
// A tag miss forces not-taken but the shared counter keeps training, so
// aliasing PCs disturb each other's counter without being predicted taken.
module branch_local_predictor
    import branch_pkg::*;
#(
    parameter int N      = BP_ENTRIES,
    parameter int IDX_W  = $clog2(N),
    parameter int PERF_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_branch_if,
    input  logic [31:0]       pc_if,
    output logic              loc_predict_taken_if,
    input  logic              is_branch_ex,
    input  logic [31:0]       pc_ex,
    input  logic              cmp_out_ex,
    input  logic              predict_taken_ex,
    output logic [PERF_W-1:0] pred_count,
    output logic [PERF_W-1:0] mispred_count
);

    bp_ctr_t           r_ctr [N];
    logic [31:0]       r_tag [N];
    logic [PERF_W-1:0] r_pred_count;
    logic [PERF_W-1:0] r_mispred_count;

    logic [IDX_W-1:0]  w_idx_if;
    logic [IDX_W-1:0]  w_idx_ex;
    bp_ctr_t           w_ctr_if;
    bp_ctr_t           w_ctr_ex;
    bp_ctr_t           w_ctr_next;
    logic              w_tag_hit_if;

    assign w_idx_if = pc_if[IDX_W+1:2];
    assign w_idx_ex = pc_ex[IDX_W+1:2];
    assign w_ctr_if = r_ctr[w_idx_if];
    assign w_ctr_ex = r_ctr[w_idx_ex];

    sat_counter2 u_sat_counter2 (
        .i_ctr   (w_ctr_ex),
        .i_taken (cmp_out_ex),
        .o_ctr   (w_ctr_next)
    );

    // Prediction from registered state only: no bypass of a same-cycle EX write.
    always_comb begin
        w_tag_hit_if         = (r_tag[w_idx_if] == pc_if);
        loc_predict_taken_if = is_branch_if && w_tag_hit_if &&
                               ((w_ctr_if == WT) || (w_ctr_if == ST));
    end

    // Table update; reset clears every entry at once and wins over an EX write.
    // The tag is replaced on every update but the counter continues from its old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_ctr[i] <= BP_CTR_INIT;
                r_tag[i] <= '0;
            end
        end else if (is_branch_ex) begin
            r_ctr[w_idx_ex] <= w_ctr_next;
            r_tag[w_idx_ex] <= pc_ex;
        end
    end

    // Resolved-branch and misprediction counters, wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pred_count    <= '0;
            r_mispred_count <= '0;
        end else if (is_branch_ex) begin
            r_pred_count <= r_pred_count + PERF_W'(1);
            if (predict_taken_ex != cmp_out_ex) begin
                r_mispred_count <= r_mispred_count + PERF_W'(1);
            end
        end
    end

    assign pred_count    = r_pred_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_local_predictor.sv
// Bench for branch_local_predictor: directed vectors plus a small random run,
// an array-based reference model checked every cycle, and literal spot checks.
module tb_branch_local_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        is_branch_if = 1'b0;
    logic [31:0] pc_if = '0;
    logic        loc_predict_taken_if;
    logic        is_branch_ex = 1'b0;
    logic [31:0] pc_ex = '0;
    logic        cmp_out_ex = 1'b0;
    logic        predict_taken_ex = 1'b0;
    logic [31:0] pred_count;
    logic [31:0] mispred_count;

    int n_vec = 0;
    int n_err = 0;

    branch_local_predictor dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .is_branch_if         (is_branch_if),
        .pc_if                (pc_if),
        .loc_predict_taken_if (loc_predict_taken_if),
        .is_branch_ex         (is_branch_ex),
        .pc_ex                (pc_ex),
        .cmp_out_ex           (cmp_out_ex),
        .predict_taken_ex     (predict_taken_ex),
        .pred_count           (pred_count),
        .mispred_count        (mispred_count)
    );

    always #5 clk = ~clk;

    // Reference model: counters as integers 0..3, tags as full PCs.
    int          m_ctr [128];
    logic [31:0] m_tag [128];
    logic [31:0] m_pred = '0;
    logic [31:0] m_mis = '0;
    bit          m_valid = 1'b0;

    function automatic int bidx(logic [31:0] pc);
        return int'((pc / 4) % 128);
    endfunction

    function automatic int step(int c, logic t);
        if (t) return (c >= 3) ? 3 : c + 1;
        else   return (c <= 0) ? 0 : c - 1;
    endfunction

    function automatic logic model_predict(logic br, logic [31:0] pc);
        return br && (m_tag[bidx(pc)] == pc) && (m_ctr[bidx(pc)] >= 2);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) begin
                m_ctr[i] <= 1;
                m_tag[i] <= '0;
            end
            m_pred  <= '0;
            m_mis   <= '0;
            m_valid <= 1'b1;
        end else if (is_branch_ex) begin
            m_ctr[bidx(pc_ex)] <= step(m_ctr[bidx(pc_ex)], cmp_out_ex);
            m_tag[bidx(pc_ex)] <= pc_ex;
            m_pred <= m_pred + 1;
            if (predict_taken_ex != cmp_out_ex) m_mis <= m_mis + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            n_vec++;
            if (loc_predict_taken_if !== model_predict(is_branch_if, pc_if)) begin
                n_err++;
                $display("FAIL model_pred pc_if=%h got=%b exp=%b", pc_if,
                         loc_predict_taken_if, model_predict(is_branch_if, pc_if));
            end
            n_vec++;
            if (pred_count !== m_pred || mispred_count !== m_mis) begin
                n_err++;
                $display("FAIL model_perf got=%0d/%0d exp=%0d/%0d",
                         pred_count, mispred_count, m_pred, m_mis);
            end
        end
    end

    task automatic drive(input logic rst, input logic ibr, input logic [31:0] pif,
                         input logic ebr, input logic [31:0] pex,
                         input logic cmp, input logic prd);
        @(posedge clk);
        #1;
        rst_n            = rst;
        is_branch_if     = ibr;
        pc_if            = pif;
        is_branch_ex     = ebr;
        pc_ex            = pex;
        cmp_out_ex       = cmp;
        predict_taken_ex = prd;
    endtask

    // EX update at pc with IF reading the same pc in that cycle.
    task automatic ex(input logic [31:0] pc, input logic cmp);
        drive(1'b1, 1'b1, pc, 1'b1, pc, cmp, 1'b0);
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic lit_pred(input string name, input logic exp);
        @(negedge clk);
        n_vec++;
        if (loc_predict_taken_if !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b", name, loc_predict_taken_if, exp);
        end
    endtask

    task automatic lit_cnt(input string name, input logic [31:0] ep, input logic [31:0] em);
        @(negedge clk);
        n_vec++;
        if (pred_count !== ep || mispred_count !== em) begin
            n_err++;
            $display("FAIL %s got=%0d/%0d exp=%0d/%0d", name, pred_count, mispred_count, ep, em);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state: tag miss at 0x40, tag hit at 0 with WNT.
        idle(32'h40);                 lit_pred("reset_0x40", 1'b0);
        idle(32'h0);                  lit_pred("reset_0x0_wnt", 1'b0);
        lit_cnt("reset_counts", 32'd0, 32'd0);

        // Single taken update; same-cycle read sees pre-update state.
        ex(32'h40, 1'b1);             lit_pred("same_cycle_no_bypass", 1'b0);
        idle(32'h40);                 lit_pred("after_taken_wt", 1'b1);

        // Saturate high, then walk down and saturate low.
        repeat (5) ex(32'h40, 1'b1);
        ex(32'h40, 1'b0);
        idle(32'h40);                 lit_pred("st_to_wt", 1'b1);
        ex(32'h40, 1'b0);
        idle(32'h40);                 lit_pred("wt_to_wnt", 1'b0);
        repeat (3) ex(32'h40, 1'b0);
        ex(32'h40, 1'b1);
        idle(32'h40);                 lit_pred("snt_sat_then_taken", 1'b0);

        // Aliasing: 0x240 shares index 0x10 with 0x40.
        repeat (3) ex(32'h40, 1'b1);
        idle(32'h40);                 lit_pred("trained_st", 1'b1);
        ex(32'h240, 1'b0);
        idle(32'h40);                 lit_pred("alias_tag_miss", 1'b0);
        idle(32'h240);                lit_pred("alias_new_owner", 1'b1);
        idle(32'h241);                lit_pred("low_bits_in_tag", 1'b0);
        drive(1'b1, 1'b0, 32'h240, 1'b0, 32'h0, 1'b0, 1'b0);
        lit_pred("not_branch_zero", 1'b0);

        // Random traffic over a few colliding PCs, checked by the model.
        for (int k = 0; k < 200; k++) begin
            logic [31:0] pcs [5];
            pcs[0] = 32'h40; pcs[1] = 32'h240; pcs[2] = 32'h44;
            pcs[3] = 32'h1000_0040; pcs[4] = 32'h41;
            drive(1'b1, 1'($urandom_range(1)), pcs[$urandom_range(4)],
                  1'($urandom_range(1)), pcs[$urandom_range(4)],
                  1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Reset with a concurrent EX update: reset wins.
        drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
        idle(32'h40);                 lit_pred("midreset_no_update", 1'b0);
        lit_cnt("midreset_counts", 32'd0, 32'd0);

        // Ten resolved branches, three mispredicted.
        for (int i = 0; i < 10; i++) begin
            logic c;
            c = 1'(i % 2);
            drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h100 + 32'(4 * i), c,
                  (i == 2 || i == 5 || i == 8) ? ~c : c);
        end
        idle(32'h0);                  lit_cnt("perf_10_3", 32'd10, 32'd3);

        // Idle EX with garbage payload leaves counters alone.
        repeat (5) drive(1'b1, 1'b0, 32'h0, 1'b0, $urandom, 1'($urandom_range(1)),
                         1'($urandom_range(1)));
        lit_cnt("perf_idle_unchanged", 32'd10, 32'd3);
        idle(32'h108);                lit_pred("perf_idle_no_table_change", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
